// File: rtl/k_cmult_pipe.sv
// Three-stage signed fixed-point complex multiplier for the FFT twiddle path.
// Rounding and saturation modes are set by parameters; sticky overflow status.
module k_cmult_pipe #(
    parameter int W     = 8,
    parameter int F     = 7,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_re,
    input  logic [W-1:0] a_im,
    input  logic [W-1:0] b_re,
    input  logic [W-1:0] b_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] p_re,
    output logic [W-1:0] p_im,
    output logic         ovf,
    input  logic         ovf_clr
);

    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 1;

    localparam logic signed [SW-1:0] HALF =
        (ROUND != 0) ? (SW'(1) << (F - 1)) : '0;
    localparam logic signed [SW-1:0] MAXV =
        {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV =
        {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic en;

    logic                s1_valid_q, s1_valid_d;
    logic signed [W-1:0] s1_are_q, s1_are_d;
    logic signed [W-1:0] s1_aim_q, s1_aim_d;
    logic signed [W-1:0] s1_bre_q, s1_bre_d;
    logic signed [W-1:0] s1_bim_q, s1_bim_d;

    logic                 s2_valid_q, s2_valid_d;
    logic signed [PW-1:0] rr_q, rr_d;
    logic signed [PW-1:0] ii_q, ii_d;
    logic signed [PW-1:0] ri_q, ri_d;
    logic signed [PW-1:0] ir_q, ir_d;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] p_re_q, p_re_d;
    logic [W-1:0] p_im_q, p_im_d;
    logic         ovf_q, ovf_d;

    logic signed [SW-1:0] sum_re, sum_im;
    logic [W:0]           fix_re, fix_im;

    // Returns {out_of_range, W-bit result} after rounding and shifting.
    function automatic logic [W:0] fix(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        logic signed [SW-1:0] q;
        logic                 hi;
        logic                 lo;
        logic [W-1:0]         v;
        r  = s + HALF;
        q  = r >>> F;
        hi = q > MAXV;
        lo = q < MINV;
        v  = q[W-1:0];
        if (SAT != 0 && hi) v = MAXV[W-1:0];
        if (SAT != 0 && lo) v = MINV[W-1:0];
        return {hi | lo, v};
    endfunction

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign p_re      = p_re_q;
    assign p_im      = p_im_q;
    assign ovf       = ovf_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_are_d   = s1_are_q;
        s1_aim_d   = s1_aim_q;
        s1_bre_d   = s1_bre_q;
        s1_bim_d   = s1_bim_q;
        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_are_d = a_re;
                s1_aim_d = a_im;
                s1_bre_d = b_re;
                s1_bim_d = b_im;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        rr_d       = rr_q;
        ii_d       = ii_q;
        ri_d       = ri_q;
        ir_d       = ir_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rr_d = PW'(s1_are_q) * PW'(s1_bre_q);
                ii_d = PW'(s1_aim_q) * PW'(s1_bim_q);
                ri_d = PW'(s1_are_q) * PW'(s1_bim_q);
                ir_d = PW'(s1_aim_q) * PW'(s1_bre_q);
            end
        end
    end

    always_comb begin
        sum_re      = SW'(rr_q) - SW'(ii_q);
        sum_im      = SW'(ri_q) + SW'(ir_q);
        fix_re      = fix(sum_re);
        fix_im      = fix(sum_im);
        out_valid_d = out_valid_q;
        p_re_d      = p_re_q;
        p_im_d      = p_im_q;
        ovf_d       = ovf_clr ? 1'b0 : ovf_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                p_re_d = fix_re[W-1:0];
                p_im_d = fix_im[W-1:0];
                // A new overflow outranks a same-cycle clear.
                if (fix_re[W] || fix_im[W]) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_are_q    <= '0;
            s1_aim_q    <= '0;
            s1_bre_q    <= '0;
            s1_bim_q    <= '0;
            s2_valid_q  <= 1'b0;
            rr_q        <= '0;
            ii_q        <= '0;
            ri_q        <= '0;
            ir_q        <= '0;
            out_valid_q <= 1'b0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_are_q    <= s1_are_d;
            s1_aim_q    <= s1_aim_d;
            s1_bre_q    <= s1_bre_d;
            s1_bim_q    <= s1_bim_d;
            s2_valid_q  <= s2_valid_d;
            rr_q        <= rr_d;
            ii_q        <= ii_d;
            ri_q        <= ri_d;
            ir_q        <= ir_d;
            out_valid_q <= out_valid_d;
            p_re_q      <= p_re_d;
            p_im_q      <= p_im_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
